clk_counter_seq: RTL and testbench

- Wishbone-master sequencer that drives one clk_counter_wb instance through a complete measurement.
- Measurement sequence: clear, arm, wait a programmable window, read the four count bytes, assemble a 32-bit result.
- Sits between a host/control FSM and the counter's 8-bit register bus, so software and top-level logic never issue raw register accesses.
- Supports single-shot and free-running (auto re-trigger) operation.

---
 rtl/clk_counter_seq_pkg.sv | 77 +++++++
 rtl/clk_counter_seq_wb_master.sv | 60 ++++++
 rtl/clk_counter_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_clk_counter_seq.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_counter_seq_pkg.sv
// Shared types, register offsets and helpers for the clk_counter measurement sequencer.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
`ifndef COUNT_STATUS
`define COUNT_STATUS 4'h0
`endif
`ifndef COUNT_0
`define COUNT_0 4'h1
`endif
`ifndef COUNT_1
`define COUNT_1 4'h2
`endif
`ifndef COUNT_2
`define COUNT_2 4'h3
`endif
`ifndef COUNT_3
`define COUNT_3 4'h4
`endif

package clk_counter_seq_pkg;

  // Width of the assembled measurement result: four count bytes.
  localparam int RES_W = 32;
  // Register bus address width (byte address bits [5:2]) and data width.
  localparam int ADR_W = 4;
  localparam int DAT_W = 8;

  // Register offsets of the counter slave.
  localparam logic [ADR_W-1:0] CNT_ADR_STATUS = `COUNT_STATUS;
  localparam logic [ADR_W-1:0] CNT_ADR_CNT0   = `COUNT_0;
  localparam logic [ADR_W-1:0] CNT_ADR_CNT1   = `COUNT_1;
  localparam logic [ADR_W-1:0] CNT_ADR_CNT2   = `COUNT_2;
  localparam logic [ADR_W-1:0] CNT_ADR_CNT3   = `COUNT_3;

  // STATUS write values: 1 holds the counter in clear, 0 releases and arms it.
  localparam logic [DAT_W-1:0] STATUS_CLEAR = 8'h01;
  localparam logic [DAT_W-1:0] STATUS_ARM   = 8'h00;

  // Sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_CLR1 = 4'd1,
    ST_HOLD = 4'd2,
    ST_CLR0 = 4'd3,
    ST_WAIT = 4'd4,
    ST_RD0  = 4'd5,
    ST_RD1  = 4'd6,
    ST_RD2  = 4'd7,
    ST_RD3  = 4'd8,
    ST_DONE = 4'd9,
    ST_GAP  = 4'd10
  } seq_state_t;

  // One register-bus access as issued by the sequencer.
  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } bus_req_t;

  function automatic bus_req_t bus_wr(input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] dat);
    bus_req_t r;
    r.we  = 1'b1;
    r.adr = adr;
    r.dat = dat;
    return r;
  endfunction

  function automatic bus_req_t bus_rd(input logic [ADR_W-1:0] adr);
    bus_req_t r;
    r.we  = 1'b0;
    r.adr = adr;
    r.dat = '0;
    return r;
  endfunction

endpackage

// File: rtl/clk_counter_seq_wb_master.sv
// Single-access Wishbone engine: strobes while req is held, reports ack or timeout.
// Latency: strobe in the first req cycle (one idle cycle after a previous access), done on the ack cycle.
// Backpressure: waits on m_ack_i for up to ACK_TIMEOUT strobe cycles, then gives up with timeout.
module clk_counter_wb_master
  import clk_counter_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req,
  input  logic             we,
  input  logic [ADR_W-1:0] adr,
  input  logic [DAT_W-1:0] wdat,
  output logic [DAT_W-1:0] rdat,
  output logic             ack_done,
  output logic             timeout,
  output logic [ADR_W-1:0] m_adr_o,
  output logic [DAT_W-1:0] m_dat_o,
  input  logic [DAT_W-1:0] m_dat_i,
  output logic             m_we_o,
  output logic             m_stb_o,
  input  logic             m_ack_i
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  // gap_q forces one strobe-low cycle after every completed access, so a
  // request that stays asserted with a new address still sees a bus gap.
  logic          gap_q;
  logic [TW-1:0] tmo_cnt;

  // Pins are pure functions of the sequencer's registered request, so reset
  // removes the strobe immediately and idle drives all zeros.
  assign m_stb_o  = req & ~gap_q;
  assign m_we_o   = req & we;
  assign m_adr_o  = req ? adr : '0;
  assign m_dat_o  = (req & we) ? wdat : '0;
  assign rdat     = m_dat_i;

  assign ack_done = m_stb_o & m_ack_i;
  assign timeout  = m_stb_o & ~m_ack_i & (tmo_cnt == TMO_LAST);

  // Count strobe cycles of the current access; saturates, clears whenever strobe is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gap_q   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      gap_q <= ack_done | timeout;
      if (!m_stb_o) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_LAST) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_counter_seq.sv
// Measurement sequencer: clear, arm, wait window, read four count bytes, publish a 32-bit result.
// Latency: 2 writes + CLR_HOLD + max(window,1) + 4 reads (plus bus waits) from start_i to done_o.
// Backpressure: each bus access waits for m_ack_i; start_i is ignored while busy_o is high.
module clk_counter_seq
  import clk_counter_seq_pkg::*;
#(
  parameter int               ACK_TIMEOUT = 16,
  parameter int               CLR_HOLD    = 4,
  parameter int               WIN_W       = 16,
  parameter logic [ADR_W-1:0] ADR_STATUS  = CNT_ADR_STATUS,
  parameter logic [ADR_W-1:0] ADR_CNT0    = CNT_ADR_CNT0,
  parameter logic [ADR_W-1:0] ADR_CNT1    = CNT_ADR_CNT1,
  parameter logic [ADR_W-1:0] ADR_CNT2    = CNT_ADR_CNT2,
  parameter logic [ADR_W-1:0] ADR_CNT3    = CNT_ADR_CNT3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             auto_i,
  input  logic             abort_i,
  input  logic [WIN_W-1:0] window_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [RES_W-1:0] result_o,
  output logic [ADR_W-1:0] m_adr_o,
  output logic [DAT_W-1:0] m_dat_o,
  input  logic [DAT_W-1:0] m_dat_i,
  output logic             m_we_o,
  output logic             m_stb_o,
  input  logic             m_ack_i
);

  localparam int HOLD_W = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLR_HOLD - 1);

  seq_state_t       state;
  logic             req_q;
  bus_req_t         breq_q;
  logic             abort_pend;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [DAT_W-1:0] shadow0;
  logic [DAT_W-1:0] shadow1;
  logic [DAT_W-1:0] shadow2;

  logic [DAT_W-1:0] rdat;
  logic             ack_done;
  logic             timeout;

  clk_counter_wb_master #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_master (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req      (req_q),
    .we       (breq_q.we),
    .adr      (breq_q.adr),
    .wdat     (breq_q.dat),
    .rdat     (rdat),
    .ack_done (ack_done),
    .timeout  (timeout),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_dat_i  (m_dat_i),
    .m_we_o   (m_we_o),
    .m_stb_o  (m_stb_o),
    .m_ack_i  (m_ack_i)
  );

  // Sequencer FSM with registered status outputs and bus request.
  // A bus request is raised in the same edge that enters a bus state, so the
  // strobe is already up in that state's first cycle. The window counter runs
  // down from max(window_i,1) and leaves at 1, and the hold counter leaves at
  // CLR_HOLD-1, so neither can wrap. The result is loaded in one edge from the
  // three shadow bytes plus the byte on the bus, so it never shows a mix of
  // old and new bytes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      result_o   <= '0;
      req_q      <= 1'b0;
      breq_q     <= '0;
      abort_pend <= 1'b0;
      hold_cnt   <= '0;
      win_cnt    <= '0;
      shadow0    <= '0;
      shadow1    <= '0;
      shadow2    <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            state  <= ST_CLR1;
            busy_o <= 1'b1;
            req_q  <= 1'b1;
            breq_q <= bus_wr(ADR_STATUS, STATUS_CLEAR);
          end
        end

        ST_CLR1, ST_CLR0, ST_RD0, ST_RD1, ST_RD2, ST_RD3: begin
          // An abort during an access is remembered and acted on once the access ends.
          if (abort_i) begin
            abort_pend <= 1'b1;
          end
          if (timeout) begin
            state      <= ST_IDLE;
            busy_o     <= 1'b0;
            req_q      <= 1'b0;
            breq_q     <= '0;
            abort_pend <= 1'b0;
            err_o      <= 1'b1;
          end else if (ack_done) begin
            if (abort_pend || abort_i) begin
              state      <= ST_IDLE;
              busy_o     <= 1'b0;
              req_q      <= 1'b0;
              breq_q     <= '0;
              abort_pend <= 1'b0;
            end else begin
              case (state)
                ST_CLR1: begin
                  state    <= ST_HOLD;
                  req_q    <= 1'b0;
                  breq_q   <= '0;
                  hold_cnt <= '0;
                end
                ST_CLR0: begin
                  state   <= ST_WAIT;
                  req_q   <= 1'b0;
                  breq_q  <= '0;
                  win_cnt <= (window_i == '0) ? WIN_W'(1) : window_i;
                end
                ST_RD0: begin
                  shadow0 <= rdat;
                  state   <= ST_RD1;
                  breq_q  <= bus_rd(ADR_CNT1);
                end
                ST_RD1: begin
                  shadow1 <= rdat;
                  state   <= ST_RD2;
                  breq_q  <= bus_rd(ADR_CNT2);
                end
                ST_RD2: begin
                  shadow2 <= rdat;
                  state   <= ST_RD3;
                  breq_q  <= bus_rd(ADR_CNT3);
                end
                ST_RD3: begin
                  result_o <= {rdat, shadow2, shadow1, shadow0};
                  done_o   <= 1'b1;
                  state    <= ST_DONE;
                  req_q    <= 1'b0;
                  breq_q   <= '0;
                end
                default: begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
                  req_q  <= 1'b0;
                  breq_q <= '0;
                end
              endcase
            end
          end
        end

        ST_HOLD: begin
          if (abort_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state  <= ST_CLR0;
            req_q  <= 1'b1;
            breq_q <= bus_wr(ADR_STATUS, STATUS_ARM);
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_WAIT: begin
          if (abort_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (win_cnt <= WIN_W'(1)) begin
            state  <= ST_RD0;
            req_q  <= 1'b1;
            breq_q <= bus_rd(ADR_CNT0);
          end else begin
            win_cnt <= win_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          // An abort arriving with done cancels the automatic re-trigger.
          if (auto_i && !abort_i) begin
            state <= ST_GAP;
          end else begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end

        ST_GAP: begin
          if (abort_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            state  <= ST_CLR1;
            req_q  <= 1'b1;
            breq_q <= bus_wr(ADR_STATUS, STATUS_CLEAR);
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          req_q  <= 1'b0;
          breq_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_counter_seq.sv
// Scoreboard bench for clk_counter_seq against a behavioural register slave.
// Latency: checks bus gaps (hold, window, read spacing) and the 16-cycle timeout strobe.
// Backpressure: slave ack delay is randomised; one scenario never acks a chosen register.
`timescale 1ns/1ps
module tb_clk_counter_seq;
  import clk_counter_seq_pkg::*;

  localparam int ACK_TO = 16;
  localparam int HOLD   = 4;

  logic        tb_clk = 1'b0;
  logic        rst;
  logic        start_i, auto_i, abort_i;
  logic [15:0] window_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] result_o;
  logic [3:0]  m_adr_o;
  logic [7:0]  m_dat_o, m_dat_i;
  logic        m_we_o, m_stb_o, m_ack_i;

  always #5 tb_clk = ~tb_clk;

  clk_counter_seq #(
    .ACK_TIMEOUT (ACK_TO),
    .CLR_HOLD    (HOLD),
    .WIN_W       (16)
  ) dut (
    .clk_i    (tb_clk),
    .rst_i    (rst),
    .start_i  (start_i),
    .auto_i   (auto_i),
    .abort_i  (abort_i),
    .window_i (window_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .result_o (result_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_dat_i  (m_dat_i),
    .m_we_o   (m_we_o),
    .m_stb_o  (m_stb_o),
    .m_ack_i  (m_ack_i)
  );

  // ---------------- behavioural slave ----------------
  logic [7:0] rom [0:15];
  int         ack_dly;
  bit         mute_en;
  logic [3:0] mute_adr;
  int         s_cnt;

  always @(posedge tb_clk or posedge rst) begin
    if (rst) begin
      m_ack_i <= 1'b0;
      s_cnt   <= 0;
    end else if (m_stb_o && !m_ack_i) begin
      if (s_cnt >= ack_dly && !(mute_en && m_adr_o == mute_adr)) m_ack_i <= 1'b1;
      s_cnt <= s_cnt + 1;
    end else begin
      m_ack_i <= 1'b0;
      s_cnt   <= 0;
    end
  end

  assign m_dat_i = (m_stb_o && !m_we_o) ? rom[m_adr_o] : 8'h00;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit         we;
    logic [3:0] adr;
    logic [7:0] dat;
    int         gap;
  } bus_exp_t;

  typedef struct {
    bit          is_err;
    logic [31:0] res;
    bit          busy_after;
  } ev_exp_t;

  bus_exp_t    bus_q[$];
  ev_exp_t     ev_q[$];
  logic [31:0] model_res;
  int          ev_target;
  int          ev_seen;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic push_bus(input bit we, input logic [3:0] adr, input logic [7:0] dat, input int gap);
    bus_exp_t e;
    e.we  = we;
    e.adr = adr;
    e.dat = dat;
    e.gap = gap;
    bus_q.push_back(e);
  endtask

  task automatic push_ev(input bit is_err, input logic [31:0] res, input bit busy_after);
    ev_exp_t e;
    e.is_err     = is_err;
    e.res        = res;
    e.busy_after = busy_after;
    ev_q.push_back(e);
    ev_target++;
  endtask

  // Clear/arm writes followed by the first n_reads count reads.
  task automatic push_prefix(input int w, input int n_reads);
    logic [3:0] cnt_adr [0:3];
    cnt_adr[0] = CNT_ADR_CNT0;
    cnt_adr[1] = CNT_ADR_CNT1;
    cnt_adr[2] = CNT_ADR_CNT2;
    cnt_adr[3] = CNT_ADR_CNT3;
    push_bus(1'b1, CNT_ADR_STATUS, 8'h01, -1);
    push_bus(1'b1, CNT_ADR_STATUS, 8'h00, HOLD);
    for (int i = 0; i < n_reads; i++)
      push_bus(1'b0, cnt_adr[i], 8'h00, (i == 0) ? ((w == 0) ? 1 : w) : 1);
  endtask

  task automatic push_full(input int w, input logic [31:0] v, input bit busy_after);
    push_prefix(w, 4);
    push_ev(1'b0, v, busy_after);
    model_res = v;
  endtask

  task automatic load_rom(input logic [31:0] v);
    rom[CNT_ADR_CNT0] = v[7:0];
    rom[CNT_ADR_CNT1] = v[15:8];
    rom[CNT_ADR_CNT2] = v[23:16];
    rom[CNT_ADR_CNT3] = v[31:24];
  endtask

  // ---------------- monitor ----------------
  bit       prev_stb, prev_ack, busy_chk_pend, busy_chk_val;
  int       low_cnt, rise_gap, hi_cnt;
  bus_exp_t be;
  ev_exp_t  ee;

  always @(negedge tb_clk) begin
    if (rst) begin
      prev_stb      = 1'b0;
      prev_ack      = 1'b0;
      busy_chk_pend = 1'b0;
      low_cnt       = 0;
      hi_cnt        = 0;
    end else begin
      if (busy_chk_pend) begin
        chk("busy_after_done", busy_o, busy_chk_val);
        busy_chk_pend = 1'b0;
      end
      if (m_stb_o) begin
        if (!prev_stb) begin
          rise_gap = low_cnt;
          hi_cnt   = 0;
        end
        hi_cnt++;
        low_cnt = 0;
        if (m_ack_i) begin
          if (bus_q.size() == 0) begin
            fail("unexpected_bus_access", $sformatf("adr %0h we %0b with none expected", m_adr_o, m_we_o));
          end else begin
            be = bus_q.pop_front();
            chk("bus_we", m_we_o, be.we);
            chk("bus_adr", m_adr_o, be.adr);
            if (be.we) chk("bus_wdat", m_dat_o, be.dat);
            if (be.gap >= 0) chk("bus_gap", rise_gap, be.gap);
          end
        end
      end else begin
        if (prev_stb && !prev_ack) chk("timeout_stb_cycles", hi_cnt, ACK_TO);
        low_cnt++;
      end
      prev_stb = m_stb_o;
      prev_ack = m_ack_i;
      if (done_o || err_o) begin
        if (ev_q.size() == 0) begin
          fail("unexpected_event", $sformatf("done %0b err %0b with none expected", done_o, err_o));
        end else begin
          ee = ev_q.pop_front();
          chk("event_err_flag", err_o, ee.is_err);
          chk("event_done_flag", done_o, !ee.is_err);
          chk("event_result", result_o, ee.res);
          if (ee.is_err) begin
            chk("err_busy", busy_o, 1'b0);
          end else begin
            busy_chk_pend = 1'b1;
            busy_chk_val  = ee.busy_after;
          end
        end
        ev_seen++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge tb_clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    cyc(1);
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1'b1);
  endtask

  task automatic wait_ev(input int n, input int budget);
    int k;
    k = 0;
    while (ev_seen < n && k < budget) begin
      cyc(1);
      k++;
    end
    if (ev_seen < n) fail("wait_event", $sformatf("seen %0d events after %0d cycles, expected %0d", ev_seen, budget, n));
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy_o && k < budget) begin
      cyc(1);
      k++;
    end
    if (busy_o) fail("wait_idle", $sformatf("busy_o still 1 after %0d cycles, expected 0", budget));
  endtask

  task automatic wait_stb(input logic [3:0] adr, input bit any_adr, input int budget);
    int k;
    k = 0;
    while (!(m_stb_o && (any_adr || m_adr_o == adr)) && k < budget) begin
      cyc(1);
      k++;
    end
    if (!m_stb_o) fail("wait_strobe", $sformatf("no strobe after %0d cycles, expected one", budget));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_err"}, err_o, 1'b0);
    chk({tag, "_result"}, result_o, 32'h0);
    chk({tag, "_stb"}, m_stb_o, 1'b0);
    chk({tag, "_we"}, m_we_o, 1'b0);
    chk({tag, "_adr"}, m_adr_o, 4'h0);
    chk({tag, "_dat"}, m_dat_o, 8'h0);
  endtask

  // ---------------- scenarios ----------------
  logic [31:0] v;
  int          w;

  initial begin
    checks = 0; errors = 0; ev_target = 0; ev_seen = 0; model_res = 32'h0;
    rst = 1'b1; start_i = 1'b0; auto_i = 1'b0; abort_i = 1'b0; window_i = 16'd0;
    ack_dly = 0; mute_en = 1'b0; mute_adr = 4'h0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    cyc(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc(2);

    // Directed single shot.
    v = 32'h12345678;
    load_rom(v);
    window_i = 16'd20;
    push_full(20, v, 1'b0);
    pulse_start();
    wait_ev(ev_target, 300);
    wait_idle(20);

    // Randomised single shots.
    for (int it = 0; it < 6; it++) begin
      v = $urandom;
      w = $urandom_range(0, 40);
      ack_dly = $urandom_range(0, 3);
      load_rom(v);
      window_i = 16'(w);
      push_full(w, v, 1'b0);
      pulse_start();
      wait_ev(ev_target, 400);
      wait_idle(20);
    end
    ack_dly = 0;

    // start_i while busy must not launch a second sequence.
    v = $urandom;
    load_rom(v);
    window_i = 16'd30;
    push_full(30, v, 1'b0);
    pulse_start();
    cyc(8);
    pulse_start();
    wait_ev(ev_target, 300);
    wait_idle(20);
    cyc(15);

    // Timeout on CNT2: error pulse, result kept.
    load_rom($urandom);
    mute_en = 1'b1;
    mute_adr = CNT_ADR_CNT2;
    window_i = 16'd5;
    push_prefix(5, 2);
    push_ev(1'b1, model_res, 1'b0);
    pulse_start();
    wait_ev(ev_target, 300);
    wait_idle(5);
    chk("timeout_result_kept", result_o, model_res);
    chk("timeout_stb_low", m_stb_o, 1'b0);
    mute_en = 1'b0;
    cyc(3);

    // Auto mode: three measurements, auto cleared after the second done.
    v = $urandom;
    load_rom(v);
    window_i = 16'd10;
    auto_i = 1'b1;
    push_full(10, v, 1'b1);
    push_full(10, v, 1'b1);
    push_full(10, v, 1'b0);
    pulse_start();
    wait_ev(ev_target - 1, 400);
    auto_i = 1'b0;
    wait_ev(ev_target, 300);
    wait_idle(20);
    cyc(30);

    // Abort during RD1 with a slow slave: RD1 completes, nothing after it.
    load_rom($urandom);
    ack_dly = 3;
    window_i = 16'd8;
    push_prefix(8, 2);
    pulse_start();
    wait_stb(CNT_ADR_CNT1, 1'b0, 300);
    abort_i = 1'b1;
    cyc(1);
    abort_i = 1'b0;
    wait_idle(40);
    cyc(15);
    chk("abort_rd1_trace_left", bus_q.size(), 0);
    chk("abort_rd1_no_done", ev_seen, ev_target);
    ack_dly = 0;

    // Abort during the window wait.
    window_i = 16'd30;
    push_prefix(30, 0);
    pulse_start();
    cyc(14);
    abort_i = 1'b1;
    cyc(1);
    abort_i = 1'b0;
    cyc(1);
    chk("abort_wait_busy", busy_o, 1'b0);
    cyc(40);
    chk("abort_wait_trace_left", bus_q.size(), 0);

    // Abort and start together in IDLE: abort wins.
    cyc(1);
    start_i = 1'b1;
    abort_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("abort_start_busy", busy_o, 1'b0);
    cyc(5);
    chk("abort_start_stb", m_stb_o, 1'b0);

    // Reset while strobing: outputs clear without waiting for a clock edge.
    ack_dly = 10;
    v = $urandom;
    load_rom(v);
    window_i = 16'd5;
    push_full(5, v, 1'b0);
    pulse_start();
    wait_stb(4'h0, 1'b1, 50);
    #1;
    rst = 1'b1;
    bus_q.delete();
    ev_q.delete();
    ev_target = ev_seen;
    model_res = 32'h0;
    #1;
    check_reset_outputs("async_reset");
    cyc(2);
    rst = 1'b0;
    ack_dly = 0;
    cyc(2);

    // Zero window behaves as a one-cycle window.
    v = $urandom;
    load_rom(v);
    window_i = 16'd0;
    push_full(0, v, 1'b0);
    pulse_start();
    wait_ev(ev_target, 300);
    wait_idle(20);
    cyc(10);

    chk("bus_queue_drained", bus_q.size(), 0);
    chk("event_queue_drained", ev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500 us, expected completion");
    $fatal(1);
  end

endmodule
